// File: rtl/uart_rx_oversampled.sv
// UART receiver (8N1/8E1/8O1) clocked by the system clock, using a tick-enable
// oversampler, 3-sample majority vote at mid-bit and a valid/ready holding register.
module uart_rx_oversampled #(
  parameter int CLOCK_RATE = 25000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_Rx_Serial,
  input  logic       i_Rx_Ready,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Valid,
  output logic       o_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Overrun,
  output logic       o_Rx_Busy
);

  localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam int MID     = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SAMP_A   = SC_W'(MID - 1);
  localparam logic [SC_W-1:0]  SAMP_B   = SC_W'(MID);
  localparam logic [SC_W-1:0]  SAMP_DEC = SC_W'(MID + 1);
  localparam logic [SC_W-1:0]  SAMP_END = SC_W'(OVERSAMPLE - 1);
  localparam logic             ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t           state_reg;
  logic             sync1_reg, sync2_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [SC_W-1:0]  sample_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             vote_a_reg, vote_b_reg;
  logic             par_mis_reg;
  logic             load_req_reg;

  logic s, tick, at_a, at_b, at_dec, at_end, vote;

  assign s      = sync2_reg;
  assign tick   = (div_cnt_reg == DIV_LAST);
  assign at_a   = (sample_cnt_reg == SAMP_A);
  assign at_b   = (sample_cnt_reg == SAMP_B);
  assign at_dec = (sample_cnt_reg == SAMP_DEC);
  assign at_end = (sample_cnt_reg == SAMP_END);
  // Third vote is the live synced sample at the decision point.
  assign vote   = (vote_a_reg & vote_b_reg) | (vote_a_reg & s) | (vote_b_reg & s);

  assign o_Rx_Busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      sync1_reg      <= 1'b1;
      sync2_reg      <= 1'b1;
      div_cnt_reg    <= '0;
      sample_cnt_reg <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      vote_a_reg     <= 1'b0;
      vote_b_reg     <= 1'b0;
      par_mis_reg    <= 1'b0;
      load_req_reg   <= 1'b0;
      o_Rx_Byte      <= 8'h00;
      o_Rx_Valid     <= 1'b0;
      o_Parity_Err   <= 1'b0;
      o_Frame_Err    <= 1'b0;
      o_Overrun      <= 1'b0;
    end else begin
      sync1_reg    <= i_Rx_Serial;
      sync2_reg    <= sync1_reg;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Overrun    <= 1'b0;
      load_req_reg <= 1'b0;

      div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
      if (state_reg != IDLE && tick)
        sample_cnt_reg <= at_end ? '0 : sample_cnt_reg + 1'b1;
      if (tick && at_a) vote_a_reg <= s;
      if (tick && at_b) vote_b_reg <= s;

      case (state_reg)
        IDLE: begin
          if (!s) begin
            state_reg      <= START;
            div_cnt_reg    <= '0;
            sample_cnt_reg <= '0;
            bit_idx_reg    <= '0;
            par_mis_reg    <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (at_dec && vote)
              state_reg <= IDLE;
            else if (at_end)
              state_reg <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (at_dec)
              shift_reg <= {vote, shift_reg[7:1]};
            if (at_end) begin
              if (bit_idx_reg == 3'd7)
                state_reg <= (PARITY_EN != 0) ? PARITY : STOP;
              else
                bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (at_dec)
              par_mis_reg <= vote ^ (^shift_reg) ^ ODD;
            if (at_end)
              state_reg <= STOP;
          end
        end
        STOP: begin
          // Decide at mid-bit so the next start edge is never missed.
          if (tick && at_dec) begin
            if (vote) begin
              load_req_reg <= 1'b1;
              state_reg    <= IDLE;
            end else begin
              o_Frame_Err <= 1'b1;
              state_reg   <= BREAK;
            end
          end
        end
        BREAK: begin
          if (s) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (load_req_reg) begin
        if (!o_Rx_Valid || i_Rx_Ready) begin
          o_Rx_Byte    <= shift_reg;
          o_Rx_Valid   <= 1'b1;
          o_Parity_Err <= par_mis_reg;
        end else begin
          o_Overrun <= 1'b1;
        end
      end else if (i_Rx_Ready && o_Rx_Valid) begin
        o_Rx_Valid <= 1'b0;
      end
    end
  end

endmodule
